// File: rtl/input_sync_debounce.sv
// input_sync_debounce: multi-channel async input synchroniser, debounce filter and edge pulses
module input_sync_debounce #(
   parameter int WIDTH    = 4,
   parameter int STAGES   = 2,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]             lvl, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
   assign lvl        = sync_q[STAGES-1];
   assign sync_out   = out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   // plain shift chain; stage 0 is the only flop that sees the async domain
   always_ff @(posedge clk)
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], async_in};
   // per channel: a mismatch must persist DEBOUNCE evaluations before the level is accepted
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (lvl[i] == out_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]  = '0;
            out_d[i]  = lvl[i];
            rise_d[i] = lvl[i];
            fall_d[i] = ~lvl[i];
         end
         else cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end
   // debounce state and registered outputs; reset clears everything without producing pulses
   always_ff @(posedge clk)
      if (rst) begin
         cnt_q  <= '0;
         out_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end
      else begin
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
endmodule
